skew_feed_ctrl: RTL and testbench

SKEW_FEED_CTRL -- requirements
Module: skew_feed_ctrl

---
 rtl/skew_feed_ctrl.sv | 170 +++++++++++++++++
 tb/tb_skew_feed_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: streams cfg_len ifmap vectors from a buffer into the
// per-row skew FIFOs, then shifts in ARRAY_HEIGHT-1 zero vectors so the
// last vector reaches the bottom row.
// Optional feature macro: SKEW_FEED_CTRL_PERF_CNT_EN adds the stall_cycles
// counter output.
module skew_feed_ctrl #(
  parameter int IFMAP_WIDTH  = 16,
  parameter int ARRAY_HEIGHT = 4,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [LEN_WIDTH-1:0]                cfg_len,
  input  logic                                stall,
  output logic                                rd_en,
  output logic [LEN_WIDTH-1:0]                rd_addr,
  input  logic [ARRAY_HEIGHT*IFMAP_WIDTH-1:0] rd_data,
  output logic                                fifo_en,
  output logic                                fifo_enq,
  output logic [ARRAY_HEIGHT*IFMAP_WIDTH-1:0] fifo_d,
  output logic                                busy,
`ifdef SKEW_FEED_CTRL_PERF_CNT_EN
  output logic [31:0]                         stall_cycles,
`endif
  output logic                                done
);

  // A single-row array needs no drain phase.
  localparam bit NO_DRAIN = (ARRAY_HEIGHT < 2);
  localparam int DCW      = (ARRAY_HEIGHT > 2) ? $clog2(ARRAY_HEIGHT - 1) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = (ARRAY_HEIGHT > 1) ? DCW'(ARRAY_HEIGHT - 2) : {DCW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 issued_q, issued_d;   // every read has been issued
  logic                 pend_q, pend_d;       // read data waiting to be enqueued
  logic [DCW-1:0]       dcnt_q, dcnt_d;
  logic                 start_acc_s;

  assign rd_addr = addr_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= {LEN_WIDTH{1'b0}};
      len_q    <= {LEN_WIDTH{1'b0}};
      issued_q <= 1'b0;
      pend_q   <= 1'b0;
      dcnt_q   <= {DCW{1'b0}};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      pend_q   <= pend_d;
      dcnt_q   <= dcnt_d;
    end
  end

  // Next-state logic and outputs; a stall freezes every piece of progress.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    pend_d      = pend_q;
    dcnt_d      = dcnt_q;
    start_acc_s = 1'b0;
    rd_en       = 1'b0;
    fifo_en     = 1'b0;
    fifo_enq    = 1'b0;
    fifo_d      = {(ARRAY_HEIGHT*IFMAP_WIDTH){1'b0}};
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          len_d       = cfg_len;
          addr_d      = {LEN_WIDTH{1'b0}};
          issued_d    = 1'b0;
          pend_d      = 1'b0;
          dcnt_d      = {DCW{1'b0}};
          state_d     = (cfg_len == {LEN_WIDTH{1'b0}}) ? ST_DONE : ST_FEED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FEED: begin
        busy = 1'b1;
        if (!stall) begin
          if (!issued_q) begin
            rd_en    = 1'b1;
            addr_d   = addr_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            issued_d = (addr_q == (len_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1}));
          end else begin
            rd_en = 1'b0;
          end
          pend_d = !issued_q;
          if (pend_q) begin
            fifo_en  = 1'b1;
            fifo_enq = 1'b1;
            fifo_d   = rd_data;
            // Data pending after the final read is the last vector.
            if (issued_q) begin
              state_d = NO_DRAIN ? ST_DONE : ST_DRAIN;
            end else begin
              state_d = ST_FEED;
            end
          end else begin
            state_d = ST_FEED;
          end
        end else begin
          state_d = ST_FEED;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!stall) begin
          fifo_en = 1'b1;
          if (dcnt_q == DRAIN_LAST) begin
            dcnt_d  = {DCW{1'b0}};
            state_d = ST_DONE;
          end else begin
            dcnt_d  = dcnt_q + {{(DCW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        addr_d  = {LEN_WIDTH{1'b0}};
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef SKEW_FEED_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  assign stall_cycles = stall_cnt_q;

  // Saturating count of stalled busy cycles, cleared per accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (start_acc_s) begin
      stall_cnt_q <= 32'd0;
    end else if (busy && stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_skew_feed_ctrl.sv
// Directed self-checking bench for skew_feed_ctrl (ARRAY_HEIGHT=4).
module tb_skew_feed_ctrl;

  localparam int W = 16;
  localparam int H = 4;
  localparam int L = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [L-1:0] cfg_len = '0;
  logic         stall = 1'b0;
  logic         rd_en;
  logic [L-1:0] rd_addr;
  logic [H*W-1:0] rd_data = '0;
  logic         fifo_en;
  logic         fifo_enq;
  logic [H*W-1:0] fifo_d;
  logic         busy;
  logic         done;
`ifdef SKEW_FEED_CTRL_PERF_CNT_EN
  logic [31:0]  stall_cycles;
`endif

  int total = 0;
  int passes = 0;

  skew_feed_ctrl #(.IFMAP_WIDTH(W), .ARRAY_HEIGHT(H), .LEN_WIDTH(L)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .fifo_en(fifo_en), .fifo_enq(fifo_enq), .fifo_d(fifo_d), .busy(busy),
`ifdef SKEW_FEED_CTRL_PERF_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Vector stored at address a: lane i holds a+1+i.
  function automatic logic [H*W-1:0] vec(input int a);
    logic [H*W-1:0] v;
    v = '0;
    for (int i = 0; i < H; i++) v[i*W +: W] = W'(a + 1 + i);
    return v;
  endfunction

  // Buffer model: one-cycle read latency, data held while rd_en is low.
  always @(posedge clk) begin
    if (rd_en) rd_data <= vec(int'(rd_addr));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Advance one cycle, drive this cycle's inputs, let outputs settle.
  task automatic step(input logic st, input int len, input logic stl, input logic r);
    @(posedge clk);
    #1;
    start = st; cfg_len = L'(len); stall = stl; rst = r;
    #1;
  endtask

  task automatic expect_o(input string tag, input logic e_rd, input int e_addr,
                          input logic e_fen, input logic e_enq, input logic [H*W-1:0] e_d,
                          input logic e_busy, input logic e_done);
    chk({tag, ".rd_en"}, 64'(rd_en), 64'(e_rd));
    if (e_rd) chk({tag, ".rd_addr"}, 64'(rd_addr), 64'(e_addr));
    chk({tag, ".fifo_en"}, 64'(fifo_en), 64'(e_fen));
    chk({tag, ".fifo_enq"}, 64'(fifo_enq), 64'(e_enq));
    chk({tag, ".fifo_d"}, 64'(fifo_d), 64'(e_d));
    chk({tag, ".busy"}, 64'(busy), 64'(e_busy));
    chk({tag, ".done"}, 64'(done), 64'(e_done));
  endtask

  localparam logic [H*W-1:0] Z = '0;

  initial begin
    // Reset state
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    expect_o("reset", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    chk("reset.rd_addr", 64'(rd_addr), 64'd0);

    // Nominal run, len 3
    step(1'b1, 3, 1'b0, 1'b0); expect_o("nom_c0", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    step(1'b0, 3, 1'b0, 1'b0); expect_o("nom_c1", 1'b1, 0, 1'b0, 1'b0, Z, 1'b1, 1'b0);
    step(1'b0, 3, 1'b0, 1'b0); expect_o("nom_c2", 1'b1, 1, 1'b1, 1'b1, vec(0), 1'b1, 1'b0);
    step(1'b0, 3, 1'b0, 1'b0); expect_o("nom_c3", 1'b1, 2, 1'b1, 1'b1, vec(1), 1'b1, 1'b0);
    step(1'b0, 3, 1'b0, 1'b0); expect_o("nom_c4", 1'b0, 0, 1'b1, 1'b1, vec(2), 1'b1, 1'b0);
    for (int c = 5; c <= 7; c++) begin
      step(1'b0, 3, 1'b0, 1'b0); expect_o($sformatf("nom_c%0d", c), 1'b0, 0, 1'b1, 1'b0, Z, 1'b1, 1'b0);
    end
    step(1'b0, 3, 1'b0, 1'b0); expect_o("nom_c8", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b1);
    step(1'b0, 3, 1'b0, 1'b0); expect_o("nom_c9", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);

    // Stall during FEED, cycles 3-4
    step(1'b1, 3, 1'b0, 1'b0); expect_o("stl_c0", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    step(1'b0, 3, 1'b0, 1'b0); expect_o("stl_c1", 1'b1, 0, 1'b0, 1'b0, Z, 1'b1, 1'b0);
    step(1'b0, 3, 1'b0, 1'b0); expect_o("stl_c2", 1'b1, 1, 1'b1, 1'b1, vec(0), 1'b1, 1'b0);
    step(1'b0, 3, 1'b1, 1'b0); expect_o("stl_c3", 1'b0, 0, 1'b0, 1'b0, Z, 1'b1, 1'b0);
    chk("stl_c3.rd_addr_hold", 64'(rd_addr), 64'd2);
    step(1'b0, 3, 1'b1, 1'b0); expect_o("stl_c4", 1'b0, 0, 1'b0, 1'b0, Z, 1'b1, 1'b0);
    step(1'b0, 3, 1'b0, 1'b0); expect_o("stl_c5", 1'b1, 2, 1'b1, 1'b1, vec(1), 1'b1, 1'b0);
    step(1'b0, 3, 1'b0, 1'b0); expect_o("stl_c6", 1'b0, 0, 1'b1, 1'b1, vec(2), 1'b1, 1'b0);
    for (int c = 7; c <= 9; c++) begin
      step(1'b0, 3, 1'b0, 1'b0); expect_o($sformatf("stl_c%0d", c), 1'b0, 0, 1'b1, 1'b0, Z, 1'b1, 1'b0);
    end
    step(1'b0, 3, 1'b0, 1'b0); expect_o("stl_c10", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b1);
`ifdef SKEW_FEED_CTRL_PERF_CNT_EN
    chk("stl.stall_cycles", 64'(stall_cycles), 64'd2);
`endif

    // Zero length
    step(1'b1, 0, 1'b0, 1'b0); expect_o("zero_c0", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0); expect_o("zero_c1", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0); expect_o("zero_c2", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);

    // Start during FEED with another length is ignored
    step(1'b1, 2, 1'b0, 1'b0); expect_o("ign_c0", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    step(1'b0, 2, 1'b0, 1'b0); expect_o("ign_c1", 1'b1, 0, 1'b0, 1'b0, Z, 1'b1, 1'b0);
    step(1'b1, 5, 1'b0, 1'b0); expect_o("ign_c2", 1'b1, 1, 1'b1, 1'b1, vec(0), 1'b1, 1'b0);
    step(1'b0, 5, 1'b0, 1'b0); expect_o("ign_c3", 1'b0, 0, 1'b1, 1'b1, vec(1), 1'b1, 1'b0);
    for (int c = 4; c <= 6; c++) begin
      step(1'b0, 5, 1'b0, 1'b0); expect_o($sformatf("ign_c%0d", c), 1'b0, 0, 1'b1, 1'b0, Z, 1'b1, 1'b0);
    end
    step(1'b0, 5, 1'b0, 1'b0); expect_o("ign_c7", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b1);
    for (int c = 8; c <= 10; c++) begin
      step(1'b0, 5, 1'b0, 1'b0); expect_o($sformatf("ign_c%0d", c), 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    end

    // Stall on the second drain cycle, len 1
    step(1'b1, 1, 1'b0, 1'b0); expect_o("dst_c0", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    step(1'b0, 1, 1'b0, 1'b0); expect_o("dst_c1", 1'b1, 0, 1'b0, 1'b0, Z, 1'b1, 1'b0);
    step(1'b0, 1, 1'b0, 1'b0); expect_o("dst_c2", 1'b0, 0, 1'b1, 1'b1, vec(0), 1'b1, 1'b0);
    step(1'b0, 1, 1'b0, 1'b0); expect_o("dst_c3", 1'b0, 0, 1'b1, 1'b0, Z, 1'b1, 1'b0);
    step(1'b0, 1, 1'b1, 1'b0); expect_o("dst_c4", 1'b0, 0, 1'b0, 1'b0, Z, 1'b1, 1'b0);
    step(1'b0, 1, 1'b0, 1'b0); expect_o("dst_c5", 1'b0, 0, 1'b1, 1'b0, Z, 1'b1, 1'b0);
    step(1'b0, 1, 1'b0, 1'b0); expect_o("dst_c6", 1'b0, 0, 1'b1, 1'b0, Z, 1'b1, 1'b0);
    step(1'b0, 1, 1'b0, 1'b0); expect_o("dst_c7", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b1);

    // Reset mid-FEED aborts without done, then a fresh start feeds from 0
    step(1'b1, 5, 1'b0, 1'b0); expect_o("rmid_c0", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    step(1'b0, 5, 1'b0, 1'b0); expect_o("rmid_c1", 1'b1, 0, 1'b0, 1'b0, Z, 1'b1, 1'b0);
    step(1'b0, 5, 1'b0, 1'b0); expect_o("rmid_c2", 1'b1, 1, 1'b1, 1'b1, vec(0), 1'b1, 1'b0);
    step(1'b0, 5, 1'b0, 1'b1);
    step(1'b0, 5, 1'b0, 1'b1); expect_o("rmid_c4", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    chk("rmid_c4.rd_addr", 64'(rd_addr), 64'd0);
    step(1'b0, 5, 1'b0, 1'b0); expect_o("rmid_c5", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    step(1'b0, 5, 1'b0, 1'b0); expect_o("rmid_c6", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0); expect_o("rnew_c0", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b0);
    step(1'b0, 2, 1'b0, 1'b0); expect_o("rnew_c1", 1'b1, 0, 1'b0, 1'b0, Z, 1'b1, 1'b0);
    step(1'b0, 2, 1'b0, 1'b0); expect_o("rnew_c2", 1'b1, 1, 1'b1, 1'b1, vec(0), 1'b1, 1'b0);
    step(1'b0, 2, 1'b0, 1'b0); expect_o("rnew_c3", 1'b0, 0, 1'b1, 1'b1, vec(1), 1'b1, 1'b0);
    for (int c = 4; c <= 6; c++) begin
      step(1'b0, 2, 1'b0, 1'b0); expect_o($sformatf("rnew_c%0d", c), 1'b0, 0, 1'b1, 1'b0, Z, 1'b1, 1'b0);
    end
    step(1'b0, 2, 1'b0, 1'b0); expect_o("rnew_c7", 1'b0, 0, 1'b0, 1'b0, Z, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
